motor_pwm_gate: RTL and testbench

//  Multi-channel motor PWM generator that consumes the heartbeat watchdog's per-channel kill vector and tick.
//  It sits directly downstream of the watchdog and drives the H-bridge PWM/DIR/BRAKE pins.

---
 rtl/motor_pkg.sv | 15 +
 rtl/motor_pwm_channel.sv | 101 ++++++++++
 rtl/motor_pwm_gate.sv | 72 +++++++
 tb/tb_motor_pwm_gate.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// Shared definitions for the motor PWM gate: per-channel state encoding and duty saturation.
package motor_pkg;

    typedef enum logic [1:0] {
        HALT = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2,
        RAMP = 2'd3
    } ch_state_t;

    function automatic logic [31:0] duty_clamp(input logic [31:0] cmd, input logic [31:0] period);
        return (cmd > period) ? period : cmd;
    endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// One motor channel: HALT/RUN/DEAD/RAMP interlock FSM, boundary-latched duty and PWM compare.
module motor_pwm_channel
    import motor_pkg::*;
#(
    parameter int DUTY_W     = 10,
    parameter int PWM_PERIOD = 1000,
    parameter int RAMP_STEP  = 8,
    parameter int DEAD_TICKS = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kill,
    input  logic              tick_edge,
    input  logic              boundary,
    input  logic [DUTY_W-1:0] pwm_cnt,
    input  logic [DUTY_W-1:0] duty_cmd,
    input  logic              dir_cmd,
    output logic              pwm,
    output logic              dir,
    output logic              brake,
    output logic [1:0]        state_code
);

    localparam int                DCW    = $clog2(DEAD_TICKS + 2);
    localparam logic [DUTY_W-1:0] STEP   = DUTY_W'(RAMP_STEP);
    localparam logic [DCW-1:0]    DEAD_N = DCW'(DEAD_TICKS);

    ch_state_t         state, state_nxt;
    logic [DUTY_W-1:0] duty_tgt, tgt_nxt, duty_act;
    logic [DCW-1:0]    dead_cnt, dead_nxt;
    logic              dir_nxt;

    always_comb begin
        state_nxt = state;
        tgt_nxt   = duty_tgt;
        dead_nxt  = dead_cnt;
        dir_nxt   = dir;
        case (state)
            HALT: begin
                tgt_nxt = '0;
                // Re-arm only on an explicit zero command so a stale duty never restarts the motor.
                if (!kill && duty_cmd == '0) begin
                    state_nxt = RUN;
                    dir_nxt   = dir_cmd;
                end
            end
            RUN: begin
                if (kill) begin
                    state_nxt = RAMP;
                end else if (dir_cmd != dir) begin
                    state_nxt = DEAD;
                    tgt_nxt   = '0;
                    dead_nxt  = DEAD_N;
                end else begin
                    tgt_nxt = DUTY_W'(duty_clamp(32'(duty_cmd), 32'(PWM_PERIOD)));
                end
            end
            DEAD: begin
                tgt_nxt = '0;
                if (tick_edge && dead_cnt != '0)
                    dead_nxt = dead_cnt - DCW'(1);
                if (kill) begin
                    state_nxt = RAMP;
                end else if (dead_cnt == '0 && duty_act == '0) begin
                    state_nxt = RUN;
                    dir_nxt   = dir_cmd;
                end
            end
            RAMP: begin
                if (tick_edge)
                    tgt_nxt = (duty_tgt > STEP) ? duty_tgt - STEP : '0;
                if (duty_tgt == '0 && duty_act == '0)
                    state_nxt = HALT;
            end
            default: state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HALT;
            duty_tgt <= '0;
            duty_act <= '0;
            dead_cnt <= '0;
            dir      <= 1'b0;
            pwm      <= 1'b0;
        end else begin
            state    <= state_nxt;
            duty_tgt <= tgt_nxt;
            dead_cnt <= dead_nxt;
            dir      <= dir_nxt;
            if (boundary)
                duty_act <= duty_tgt;
            pwm <= (pwm_cnt < duty_act);
        end
    end

    assign brake      = (state == HALT);
    assign state_code = state;

endmodule

// File: rtl/motor_pwm_gate.sv
// Multi-channel H-bridge PWM driver gated by the heartbeat watchdog kill vector and tick.
module motor_pwm_gate
    import motor_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int DUTY_W     = 10,
    parameter int PWM_PERIOD = 1000,
    parameter int RAMP_STEP  = 8,
    parameter int DEAD_TICKS = 5
) (
    input  logic                  clk_50Mhz,
    input  logic                  rst,
    input  logic [31:0]           wd_reset,
    input  logic                  tick_10khz,
    input  logic [NCH*DUTY_W-1:0] duty_cmd,
    input  logic [NCH-1:0]        dir_cmd,
    output logic [NCH-1:0]        pwm_out,
    output logic [NCH-1:0]        dir_out,
    output logic [NCH-1:0]        brake_out,
    output logic [2*NCH-1:0]      ch_state,
    output logic                  kill_active
);

    localparam logic [DUTY_W-1:0] LAST = DUTY_W'(PWM_PERIOD - 1);

    logic [DUTY_W-1:0] pwm_cnt;
    logic              boundary, tick_q, tick_edge;

    assign boundary  = (pwm_cnt == LAST);
    assign tick_edge = tick_10khz & ~tick_q;

    // kill_active is registered so it also reads 0 while rst is held.
    always_ff @(posedge clk_50Mhz) begin
        if (rst) begin
            pwm_cnt     <= '0;
            tick_q      <= 1'b0;
            kill_active <= 1'b0;
        end else begin
            pwm_cnt     <= boundary ? '0 : pwm_cnt + DUTY_W'(1);
            tick_q      <= tick_10khz;
            kill_active <= |wd_reset[NCH-1:0];
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        motor_pwm_channel #(
            .DUTY_W    (DUTY_W),
            .PWM_PERIOD(PWM_PERIOD),
            .RAMP_STEP (RAMP_STEP),
            .DEAD_TICKS(DEAD_TICKS)
        ) u_ch (
            .clk       (clk_50Mhz),
            .rst       (rst),
            .kill      (wd_reset[i]),
            .tick_edge (tick_edge),
            .boundary  (boundary),
            .pwm_cnt   (pwm_cnt),
            .duty_cmd  (duty_cmd[i*DUTY_W +: DUTY_W]),
            .dir_cmd   (dir_cmd[i]),
            .pwm       (pwm_out[i]),
            .dir       (dir_out[i]),
            .brake     (brake_out[i]),
            .state_code(ch_state[2*i +: 2])
        );
    end

    if (NCH < 32) begin : g_unused
        logic unused_kill;
        assign unused_kill = |wd_reset[31:NCH];
    end

endmodule

// File: tb/tb_motor_pwm_gate.sv
// Scoreboard bench for motor_pwm_gate: duty, clamp, kill ramp, re-arm, dead time, reset.
module tb_motor_pwm_gate;

    localparam int NCH = 4;
    localparam int DW  = 10;
    localparam int PER = 1000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [31:0]       wd_reset = '0;
    logic              tick_10khz = 1'b0;
    logic [NCH*DW-1:0] duty_cmd = '0;
    logic [NCH-1:0]    dir_cmd = '0;
    logic [NCH-1:0]    pwm_out, dir_out, brake_out;
    logic [2*NCH-1:0]  ch_state;
    logic              kill_active;

    int vectors = 0;
    int miscompares = 0;
    int bcnt;
    int kl_low;
    int h [NCH];

    typedef struct {
        string       tag;
        int unsigned val;
    } exp_t;
    exp_t sb[$];

    motor_pwm_gate dut (
        .clk_50Mhz  (clk),
        .rst        (rst),
        .wd_reset   (wd_reset),
        .tick_10khz (tick_10khz),
        .duty_cmd   (duty_cmd),
        .dir_cmd    (dir_cmd),
        .pwm_out    (pwm_out),
        .dir_out    (dir_out),
        .brake_out  (brake_out),
        .ch_state   (ch_state),
        .kill_active(kill_active)
    );

    always #10 clk = ~clk;

    // Reference period position; tick rises once every 100 clocks, phase-locked to it.
    always @(posedge clk) begin
        if (rst) bcnt <= 0;
        else     bcnt <= (bcnt == PER - 1) ? 0 : bcnt + 1;
    end

    always @(negedge clk) tick_10khz = (bcnt % 100) < 50;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input int unsigned v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop(input int unsigned obs);
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_underrun", sb.size(), 1);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_duty(input int ch, input int v);
        duty_cmd[ch*DW +: DW] = DW'(v);
    endtask

    task automatic wait_cnt(input int v);
        int n = 0;
        while (bcnt != v && n < 2 * PER) begin
            step(1);
            n++;
        end
        if (bcnt != v) chk("align", bcnt, v);
    endtask

    // High-clock count per channel over one full PWM period.
    task automatic period_hi(output int hi [NCH]);
        wait_cnt(1);
        for (int c = 0; c < NCH; c++) hi[c] = 0;
        for (int i = 0; i < PER; i++) begin
            for (int c = 0; c < NCH; c++) if (pwm_out[c]) hi[c]++;
            if (!kill_active) kl_low++;
            if (i < PER - 1) step(1);
        end
    endtask

    task automatic push_reset(input string pfx);
        push({pfx, "_pwm"}, 0);
        push({pfx, "_dir"}, 0);
        push({pfx, "_brake"}, 4'hF);
        push({pfx, "_state"}, 0);
        push({pfx, "_kill"}, 0);
    endtask

    task automatic pop_reset();
        pop(pwm_out);
        pop(dir_out);
        pop(brake_out);
        pop(ch_state);
        pop(kill_active);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got 0 want 1 (run did not finish)");
        $fatal(1, "timeout");
    end

    initial begin
        push_reset("rst");
        step(3);
        pop_reset();

        // Release reset with zero commands: every channel re-arms.
        rst = 1'b0;
        push("arm_state", 8'h55);
        push("arm_brake", 0);
        step(2);
        pop(ch_state);
        pop(brake_out);

        // Basic duty on two channels.
        set_duty(0, 250);
        set_duty(1, 500);
        push("t1_duty0", 250);
        push("t1_duty1", 500);
        period_hi(h);
        period_hi(h);
        pop(h[0]);
        pop(h[1]);

        // Over-range command clamps to 100 %; zero holds until the boundary.
        set_duty(0, 1023);
        push("t2_clamp", PER);
        period_hi(h);
        period_hi(h);
        pop(h[0]);
        wait_cnt(200);
        set_duty(0, 0);
        push("t2_hold", 1);
        push("t2_zero", 0);
        step(100);
        pop(pwm_out[0]);
        period_hi(h);
        pop(h[0]);

        // Kill at duty 100: 9 tick edges before the first boundary (100-72=28), then 0, then HALT.
        set_duty(0, 100);
        push("t3_run", 100);
        period_hi(h);
        period_hi(h);
        pop(h[0]);
        wait_cnt(5);
        wd_reset[0] = 1'b1;
        push("t3_ramp_state", 3);
        push("t3_kill", 1);
        push("t3_p1", 28);
        push("t3_p2", 0);
        push("t3_kill_low", 0);
        push("t3_halt", 0);
        push("t3_brake", 1);
        step(2);
        pop(ch_state[1:0]);
        pop(kill_active);
        kl_low = 0;
        period_hi(h);
        pop(h[0]);
        period_hi(h);
        pop(h[0]);
        pop(kl_low);
        step(2);
        pop(ch_state[1:0]);
        pop(brake_out[0]);

        // Re-arm interlock: nonzero command keeps HALT, zero command re-arms.
        wd_reset[0] = 1'b0;
        set_duty(0, 300);
        push("t4_hold", 0);
        push("t4_hold_brake", 1);
        push("t4_rearm", 1);
        push("t4_run_brake", 0);
        step(5);
        pop(ch_state[1:0]);
        pop(brake_out[0]);
        set_duty(0, 0);
        step(2);
        pop(ch_state[1:0]);
        pop(brake_out[0]);

        // Direction reversal on ch1 at duty 500: one period off, then new direction at 500.
        push("t5_pa", 500);
        push("t5_dead_state", 2);
        push("t5_dir_hold", 0);
        push("t5_pb", 0);
        push("t5_dir_new", 1);
        push("t5_run", 1);
        push("t5_pc", 500);
        wait_cnt(1);
        dir_cmd[1] = 1'b1;
        period_hi(h);
        pop(h[1]);
        pop(ch_state[3:2]);
        pop(dir_out[1]);
        period_hi(h);
        pop(h[1]);
        pop(dir_out[1]);
        pop(ch_state[3:2]);
        period_hi(h);
        pop(h[1]);

        // Kill and direction change together: kill wins, then reset mid-ramp.
        set_duty(2, 200);
        push("t6_run", 200);
        period_hi(h);
        period_hi(h);
        pop(h[2]);
        wd_reset[2] = 1'b1;
        dir_cmd[2]  = 1'b1;
        push("t6_ramp", 3);
        push("t6_dir", 0);
        push("t6_kill", 1);
        step(2);
        pop(ch_state[5:4]);
        pop(dir_out[2]);
        pop(kill_active);
        step(50);
        rst = 1'b1;
        push_reset("t6_rst");
        step(1);
        pop_reset();
        rst = 1'b0;
        step(2);

        chk("sb_left", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
